// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational field/immediate decode of the accepted word,
// buffered in a two-entry in-order FIFO (head + skid) with a registered in_ready.
module rv_decode_stage #(
  parameter int I_WIDTH  = 32,
  parameter int PC_WIDTH = I_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [I_WIDTH-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_func3,
  output logic [6:0]          out_func7,
  output logic [I_WIDTH-1:0]  out_imm,
  output logic [8:0]          out_class,
  output logic                out_illegal
);

  // state | meaning
  // EMPTY | no decoded record buffered
  // ONE   | head holds the oldest record, skid unused
  // FULL  | head holds the oldest, skid the younger; in_ready low
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [I_WIDTH-1:0]  imm;
    logic [8:0]          cls;
    logic                illegal;
  } rec_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e      state_q, state_d;
  rec_t        head_q, head_d;
  rec_t        skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  rec_t        dec;
  logic [31:0] imm32;
  logic        push;
  logic        pop;

  always_comb begin
    dec         = '0;
    imm32       = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.rd      = in_instr[11:7];
    dec.func3   = in_instr[14:12];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.func7   = in_instr[31:25];
    case (in_instr[6:0])
      OP_LOAD: begin
        dec.cls[0] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.cls[1] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_ALU_I: begin
        dec.cls[2] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_ALU_R: begin
        dec.cls[3] = 1'b1;
      end
      OP_BRANCH: begin
        dec.cls[4] = 1'b1;
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.cls[5] = 1'b1;
        imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.cls[6] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LUI: begin
        dec.cls[7] = 1'b1;
        imm32      = {in_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.cls[8] = 1'b1;
        imm32      = {in_instr[31:12], 12'b0};
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = I_WIDTH'($signed(imm32));
  end

  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = dec;
        end else if (push) begin
          skid_d  = dec;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // A redirect empties the buffer; any in-flight pop has already been taken by execute.
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_pc      = head_q.pc;
  assign out_opcode  = head_q.opcode;
  assign out_rd      = head_q.rd;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_func3   = head_q.func3;
  assign out_func7   = head_q.func7;
  assign out_imm     = head_q.imm;
  assign out_class   = head_q.cls;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [31:0] out_imm;
  logic [8:0]  out_class;
  logic        out_illegal;

  always #5 clk = ~clk;

  rv_decode_stage #(.I_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_class(out_class), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] seen[$];
  logic        m_in_ready = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [8:0] m_class(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011: return 9'h001;
      7'b0100011: return 9'h002;
      7'b0010011: return 9'h004;
      7'b0110011: return 9'h008;
      7'b1100011: return 9'h010;
      7'b1101111: return 9'h020;
      7'b1100111: return 9'h040;
      7'b0110111: return 9'h080;
      7'b0010111: return 9'h100;
      default:    return 9'h000;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic [31:0] s;
    logic [8:0]  c;
    s = {32{ins[31]}};
    c = m_class(ins);
    if (c == 9'h001 || c == 9'h004 || c == 9'h040) return 32'($signed(ins) >>> 20);
    if (c == 9'h002) return (s << 11) | ((ins >> 20) & 32'hFE0) | ((ins >> 7) & 32'h1F);
    if (c == 9'h010) return (s << 12) | (((ins >> 7) & 32'h1) << 11)
                           | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
    if (c == 9'h020) return (s << 20) | (ins & 32'h000FF000)
                           | (((ins >> 20) & 32'h1) << 11) | ((ins >> 20) & 32'h7FE);
    if (c == 9'h080 || c == 9'h100) return ins & 32'hFFFFF000;
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_in_ready = 1'b0;
    end else begin
      logic do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && m_in_ready && !flush;
      if (out_valid && out_ready) seen.push_back(out_pc);
      if (do_pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (do_push) mq.push_back('{instr: in_instr, pc: in_pc});
      m_in_ready = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, m_in_ready);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_opcode", out_opcode, mq[0].instr[6:0]);
      chk("out_rd", out_rd, mq[0].instr[11:7]);
      chk("out_func3", out_func3, mq[0].instr[14:12]);
      chk("out_rs1", out_rs1, mq[0].instr[19:15]);
      chk("out_rs2", out_rs2, mq[0].instr[24:20]);
      chk("out_func7", out_func7, mq[0].instr[31:25]);
      chk("out_imm", out_imm, m_imm(mq[0].instr));
      chk("out_class", out_class, m_class(mq[0].instr));
      chk("out_illegal", out_illegal, m_class(mq[0].instr) == 9'h000);
    end
  end

  task automatic push_hold(input logic [31:0] ins, input logic [31:0] pc);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 1'b0, 1'b1);
  endtask

  logic [31:0] tbl [11] = '{32'h00812083, 32'h00112423, 32'h002081B3, 32'hFE208EE3,
                            32'h000080E7, 32'h00001517, 32'h7FF00093, 32'h80000137,
                            32'h0000007F, 32'h8000006F, 32'h40208033};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("model_imm_addi", m_imm(32'hFFF10093), 32'hFFFFFFFF);
    chk("model_imm_jal", m_imm(32'hFFDFF06F), 32'hFFFFFFFC);
    chk("model_imm_beq", m_imm(32'hFE208EE3), 32'hFFFFFFFC);
    chk("model_imm_sw", m_imm(32'h00112423), 32'h00000008);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1'b1);

    push_hold(32'hFFF10093, 32'h100);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_class", out_class, 9'h004);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_rs1", out_rs1, 5'd2);
    chk("addi_func3", out_func3, 3'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_pc", out_pc, 32'h100);
    push_hold(32'h123452B7, 32'h104);
    chk("lui_class", out_class, 9'h080);
    chk("lui_rd", out_rd, 5'd5);
    chk("lui_imm", out_imm, 32'h12345000);
    push_hold(32'hFFDFF06F, 32'h108);
    chk("jal_class", out_class, 9'h020);
    chk("jal_rd", out_rd, 5'd0);
    chk("jal_imm", out_imm, 32'hFFFFFFFC);
    push_hold(32'h00000000, 32'h10C);
    chk("zero_illegal", out_illegal, 1'b1);
    chk("zero_class", out_class, 9'h000);
    chk("zero_valid", out_valid, 1'b1);
    @(negedge clk);

    // Backpressure: A,B fill the buffer, C waits.
    out_ready = 1'b0;
    seen.delete();
    push_hold(32'h00100093, 32'h200);
    push_hold(32'h00200113, 32'h204);
    chk("bp_in_ready_low", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;
    repeat (2) @(negedge clk);
    chk("bp_still_full", in_ready, 1'b0);
    chk("bp_head_stable", out_pc, 32'h200);
    out_ready = 1'b1;
    push_hold(32'h00300193, 32'h208);
    repeat (4) @(negedge clk);
    chk("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 32'h200);
      chk("bp_order1", seen[1], 32'h204);
      chk("bp_order2", seen[2], 32'h208);
    end

    // Flush while full with a coincident push.
    out_ready = 1'b0;
    seen.delete();
    push_hold(32'h00400213, 32'h300);
    push_hold(32'h00500293, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h999;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("flush_nothing_emerges", seen.size(), 0);

    // Mixed stream with intermittent backpressure.
    for (int i = 0; i < 11; i++) begin
      out_ready = ((i % 3) != 2);
      push_hold(tbl[i], 32'h400 + 32'(4 * i));
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    push_hold(32'h00700393, 32'h600);
    push_hold(32'h00800413, 32'h604);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen.delete();
    @(negedge clk);
    chk("rerst_in_ready", in_ready, 1'b1);
    push_hold(32'h00900493, 32'h700);
    repeat (3) @(negedge clk);
    chk("rerst_count", seen.size(), 1);
    if (seen.size() == 1) chk("rerst_first", seen[0], 32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
